// File: rtl/ssd_scan_ctrl.sv
// ============================================================================
// ssd_scan_ctrl : multiplexed seven-segment scanner with double-buffered data
// Rev 1.0
// ============================================================================
`default_nettype none

module ssd_scan_ctrl #(
   parameter int NUM_DIGITS = 8,
   parameter int DIV_BITS   = 18
) (
   input  logic                      ClkPort,
   input  logic                      Reset_n,
   input  logic                      load,
   input  logic [4*NUM_DIGITS-1:0]   digits_in,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic [NUM_DIGITS-1:0]     blank_in,
   input  logic                      lz_suppress,
   input  logic [3:0]                bright,
   output logic [NUM_DIGITS-1:0]     An,
   output logic [7:0]                Cathodes,
   output logic                      pending,
   output logic                      frame_start
);

   localparam int                  c_idx_w    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [c_idx_w-1:0]  c_last_idx = c_idx_w'(NUM_DIGITS - 1);

   logic [DIV_BITS-1:0]     r_presc;
   logic [c_idx_w-1:0]      r_idx;
   logic                    r_pending;
   logic                    r_frame_start;
   logic [NUM_DIGITS-1:0]   r_an;
   logic [7:0]              r_cat;

   logic [4*NUM_DIGITS-1:0] r_sh_digits;
   logic [NUM_DIGITS-1:0]   r_sh_dp;
   logic [NUM_DIGITS-1:0]   r_sh_blank;
   logic                    r_sh_lz;

   logic [4*NUM_DIGITS-1:0] r_act_digits;
   logic [NUM_DIGITS-1:0]   r_act_dp;
   logic [NUM_DIGITS-1:0]   r_act_blank;
   logic [NUM_DIGITS-1:0]   r_act_mask;

   logic                    w_tick;
   logic                    w_boundary;
   logic [3:0]              w_nib;
   logic                    w_pwm_on;
   logic                    w_dark;
   logic [6:0]              w_seg;
   logic [NUM_DIGITS-1:0]   w_an_sel;

   // Leading zeros run from the top digit down; digit 0 always stays visible.
   function automatic logic [NUM_DIGITS-1:0] f_lz_mask(input logic [4*NUM_DIGITS-1:0] d);
      logic [NUM_DIGITS-1:0] m;
      logic                  run;
      m   = '0;
      run = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         run  = run & (d[4*i +: 4] == 4'h0);
         m[i] = run;
      end
      return m;
   endfunction

   assign w_tick     = &r_presc;
   assign w_boundary = w_tick && (r_idx == c_last_idx);
   assign w_nib      = r_act_digits[{r_idx, 2'b00} +: 4];
   assign w_pwm_on   = (r_presc[DIV_BITS-1 -: 4] <= bright);
   assign w_dark     = r_act_blank[r_idx] | r_act_mask[r_idx] | ~w_pwm_on;

   always_ff @(posedge ClkPort or negedge Reset_n) begin
      if (!Reset_n) begin
         r_presc       <= '0;
         r_idx         <= '0;
         r_frame_start <= 1'b0;
      end else begin
         r_presc       <= r_presc + 1'b1;
         r_frame_start <= w_boundary;
         if (w_tick) begin
            r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
         end
      end
   end

   // A load landing on the boundary bypasses the shadow so it is never a frame late.
   always_ff @(posedge ClkPort or negedge Reset_n) begin
      if (!Reset_n) begin
         r_pending    <= 1'b0;
         r_sh_digits  <= '0;
         r_sh_dp      <= '0;
         r_sh_blank   <= '0;
         r_sh_lz      <= 1'b0;
         r_act_digits <= '0;
         r_act_dp     <= '0;
         r_act_blank  <= '1;
         r_act_mask   <= '0;
      end else if (w_boundary && load) begin
         r_act_digits <= digits_in;
         r_act_dp     <= dp_in;
         r_act_blank  <= blank_in;
         r_act_mask   <= lz_suppress ? f_lz_mask(digits_in) : '0;
         r_pending    <= 1'b0;
      end else if (w_boundary && r_pending) begin
         r_act_digits <= r_sh_digits;
         r_act_dp     <= r_sh_dp;
         r_act_blank  <= r_sh_blank;
         r_act_mask   <= r_sh_lz ? f_lz_mask(r_sh_digits) : '0;
         r_pending    <= 1'b0;
      end else if (load) begin
         r_sh_digits  <= digits_in;
         r_sh_dp      <= dp_in;
         r_sh_blank   <= blank_in;
         r_sh_lz      <= lz_suppress;
         r_pending    <= 1'b1;
      end
   end

   always_comb begin
      case (w_nib)
         4'h0:    w_seg = 7'b0000001;
         4'h1:    w_seg = 7'b1001111;
         4'h2:    w_seg = 7'b0010010;
         4'h3:    w_seg = 7'b0000110;
         4'h4:    w_seg = 7'b1001100;
         4'h5:    w_seg = 7'b0100100;
         4'h6:    w_seg = 7'b0100000;
         4'h7:    w_seg = 7'b0001111;
         4'h8:    w_seg = 7'b0000000;
         4'h9:    w_seg = 7'b0000100;
         4'hA:    w_seg = 7'b0001000;
         4'hB:    w_seg = 7'b1100000;
         4'hC:    w_seg = 7'b0110001;
         4'hD:    w_seg = 7'b1000010;
         4'hE:    w_seg = 7'b0110000;
         default: w_seg = 7'b0111000;
      endcase
   end

   always_comb begin
      w_an_sel        = '1;
      w_an_sel[r_idx] = 1'b0;
   end

   always_ff @(posedge ClkPort or negedge Reset_n) begin
      if (!Reset_n) begin
         r_an  <= '1;
         r_cat <= 8'hFF;
      end else begin
         r_an  <= w_dark ? '1 : w_an_sel;
         r_cat <= w_dark ? 8'hFF : {w_seg, ~r_act_dp[r_idx]};
      end
   end

   assign An          = r_an;
   assign Cathodes    = r_cat;
   assign pending     = r_pending;
   assign frame_start = r_frame_start;

endmodule

`default_nettype wire
